// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction ROM and buffers
// fetched {pc, inst} pairs in a 2-entry FIFO toward ID over valid/ready.
module inst_fetch_unit #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_pc_i,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [INST_W-1:0] rom_inst_i,
   output logic              id_valid_o,
   input  logic              id_ready_i,
   output logic [INST_W-1:0] id_inst_o,
   output logic [ADDR_W-1:0] id_pc_o
);

   typedef enum logic {
      FETCH_IDLE,
      FETCH_RUN
   } fetch_state_t;

   localparam logic [ADDR_W-1:0] PC_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

   fetch_state_t      fetch_state;
   fetch_state_t      fetch_next;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        count;
   logic              rd_ptr;
   logic              wr_ptr;
   logic [INST_W-1:0] fifo_inst [2];
   logic [ADDR_W-1:0] fifo_pc   [2];
   logic              push;
   logic              pop;
   logic              full;

   always_comb begin
      fetch_next = fetch_state;
      if (fetch_state == FETCH_IDLE) begin
         fetch_next = FETCH_RUN;
      end
   end

   assign full       = (count == 2'd2);
   assign id_valid_o = (count != 2'd0);
   assign pop        = id_valid_o & id_ready_i;
   assign push       = (fetch_state == FETCH_RUN) & ~stall_i & ~flush_i & (~full | pop);

   assign rom_ce_o   = (fetch_state == FETCH_RUN);
   assign rom_addr_o = pc;
   assign id_inst_o  = id_valid_o ? fifo_inst[rd_ptr] : '0;
   assign id_pc_o    = id_valid_o ? fifo_pc[rd_ptr]   : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_state <= FETCH_IDLE;
         pc          <= RESET_PC & PC_MASK;
         count       <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) begin
            fifo_inst[i] <= '0;
            fifo_pc[i]   <= '0;
         end
      end else begin
         fetch_state <= fetch_next;
         // Flush overrides push and pop; a pop in this cycle is still consumed by ID.
         if (flush_i) begin
            pc     <= flush_pc_i & PC_MASK;
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
         end else begin
            if (push) begin
               fifo_inst[wr_ptr] <= rom_inst_i;
               fifo_pc[wr_ptr]   <= pc;
               wr_ptr            <= ~wr_ptr;
               pc                <= pc + ADDR_W'(4);
            end
            if (pop) begin
               rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: ROM model ROM[k]=k+1, scoreboard of
// expected fetch PCs per stream segment, checked on every ID handshake.
module tb_inst_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        rom_ce_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_inst_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_inst_o;
   logic [31:0] id_pc_o;

   int          checks;
   int          failures;
   int          hs_count;
   int          hs_before;
   logic [31:0] exp_q[$];
   logic [31:0] stall_addr;
   logic [31:0] head_pc;

   inst_fetch_unit #(
      .ADDR_W  (32),
      .INST_W  (32),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stall_i   (stall_i),
      .flush_i   (flush_i),
      .flush_pc_i(flush_pc_i),
      .rom_ce_o  (rom_ce_o),
      .rom_addr_o(rom_addr_o),
      .rom_inst_i(rom_inst_i),
      .id_valid_o(id_valid_o),
      .id_ready_i(id_ready_i),
      .id_inst_o (id_inst_o),
      .id_pc_o   (id_pc_o)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] addr);
      return {2'b00, addr[31:2]} + 32'd1;
   endfunction

   assign rom_inst_i = rom_word(rom_addr_o);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic build_queue(input logic [31:0] target);
      exp_q.delete();
      for (int i = 0; i < 48; i++) exp_q.push_back(target + 32'(4 * i));
   endtask

   // One cycle: compare any handshake against the scoreboard, then advance past the edge.
   task automatic step();
      logic [31:0] e;
      @(negedge clk);
      if (id_valid_o && id_ready_i) begin
         hs_count++;
         checks++;
         assert (exp_q.size() > 0)
         else begin
            failures++;
            $error("FAIL hs_queue observed=pc_%h expected=no_transfer", id_pc_o);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hs_pc", id_pc_o, e);
            check("hs_inst", id_inst_o, rom_word(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      hs_count   = 0;
      rst        = 1'b0;
      stall_i    = 1'b0;
      flush_i    = 1'b0;
      flush_pc_i = '0;
      id_ready_i = 1'b1;

      // Reset state
      #2;
      check("rst_ce", rom_ce_o, 1'b0);
      check("rst_valid", id_valid_o, 1'b0);
      check("rst_inst", id_inst_o, 32'h0);
      check("rst_pc", id_pc_o, 32'h0);
      check("rst_addr", rom_addr_o, 32'h0);

      // 1: start-up latency and steady stream
      @(posedge clk);
      #1;
      rst = 1'b1;
      build_queue(32'h0);
      step();
      check("start_ce", rom_ce_o, 1'b1);
      check("start_valid_lo", id_valid_o, 1'b0);
      step();
      check("start_valid_hi", id_valid_o, 1'b1);
      check("start_pc", id_pc_o, 32'h0);
      check("start_inst", id_inst_o, 32'h1);
      repeat (6) begin
         step();
         check("steady_valid", id_valid_o, 1'b1);
      end

      // 2: backpressure
      id_ready_i = 1'b0;
      head_pc = exp_q[0];
      repeat (4) begin
         step();
         check("bp_valid", id_valid_o, 1'b1);
         check("bp_head_pc", id_pc_o, head_pc);
         check("bp_head_inst", id_inst_o, rom_word(head_pc));
      end
      check("bp_addr", rom_addr_o, head_pc + 32'd8);
      id_ready_i = 1'b1;
      repeat (4) begin
         step();
         check("bp_rel_valid", id_valid_o, 1'b1);
      end

      // 3: fill FIFO from 0x8 so pc reaches 0x10, then flush to 0x43
      id_ready_i = 1'b0;
      flush_i    = 1'b1;
      flush_pc_i = 32'h8;
      step();
      flush_i = 1'b0;
      build_queue(32'h8);
      check("fl0_valid", id_valid_o, 1'b0);
      check("fl0_addr", rom_addr_o, 32'h8);
      repeat (3) step();
      check("full_addr", rom_addr_o, 32'h10);
      check("full_head", id_pc_o, 32'h8);
      id_ready_i = 1'b1;
      flush_i    = 1'b1;
      flush_pc_i = 32'h43;
      step();
      flush_i = 1'b0;
      build_queue(32'h40);
      check("fl_valid", id_valid_o, 1'b0);
      check("fl_addr", rom_addr_o, 32'h40);
      check("fl_inst_zero", id_inst_o, 32'h0);
      check("fl_pc_zero", id_pc_o, 32'h0);
      step();
      check("fl_first_valid", id_valid_o, 1'b1);
      check("fl_first_pc", id_pc_o, 32'h40);
      repeat (3) step();

      // 4: stall drains FIFO, address held
      stall_addr = exp_q[0] + 32'd4;
      check("pre_stall_addr", rom_addr_o, stall_addr);
      stall_i = 1'b1;
      repeat (3) begin
         step();
         check("stall_valid", id_valid_o, 1'b0);
         check("stall_addr", rom_addr_o, stall_addr);
      end
      stall_i = 1'b0;
      step();
      check("unstall_valid", id_valid_o, 1'b1);
      check("unstall_pc", id_pc_o, stall_addr);

      // 5: PC wrap
      flush_i    = 1'b1;
      flush_pc_i = 32'hFFFF_FFF8;
      step();
      flush_i = 1'b0;
      build_queue(32'hFFFF_FFF8);
      hs_before = hs_count;
      repeat (5) step();
      check("wrap_pops", 32'(hs_count - hs_before), 32'd4);
      check("wrap_addr", rom_addr_o, 32'hC);

      // 6a: asynchronous reset between edges
      #3;
      rst = 1'b0;
      #1;
      check("arst_ce", rom_ce_o, 1'b0);
      check("arst_valid", id_valid_o, 1'b0);
      check("arst_addr", rom_addr_o, 32'h0);
      check("arst_pc", id_pc_o, 32'h0);
      check("arst_inst", id_inst_o, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      build_queue(32'h0);
      step();
      check("rerst_ce", rom_ce_o, 1'b1);
      check("rerst_valid", id_valid_o, 1'b0);
      step();
      check("rerst_pc", id_pc_o, 32'h0);
      repeat (2) step();

      // 6b: flush and stall together
      stall_i    = 1'b1;
      flush_i    = 1'b1;
      flush_pc_i = 32'h100;
      step();
      flush_i = 1'b0;
      build_queue(32'h100);
      check("fs_valid", id_valid_o, 1'b0);
      check("fs_addr", rom_addr_o, 32'h100);
      step();
      check("fs_hold_valid", id_valid_o, 1'b0);
      check("fs_hold_addr", rom_addr_o, 32'h100);
      stall_i = 1'b0;
      step();
      check("fs_resume_valid", id_valid_o, 1'b1);
      check("fs_resume_pc", id_pc_o, 32'h100);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
